// File: rtl/conv1d_tap_sequencer_if.sv
// rtl/conv1d_tap_sequencer_if.sv - run control, MAC strobe/address and result handshake bundle
interface conv1d_tap_sequencer_if #(
    parameter int ADDR_W = 3,
    parameter int NOUT_W = 8
);
    logic              start;
    logic [NOUT_W-1:0] num_out;
    logic              busy;
    logic [ADDR_W-1:0] tap_addr;
    logic [NOUT_W:0]   data_addr;
    logic [NOUT_W-1:0] out_idx;
    logic              mac_clr;
    logic              mac_en;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    modport master (
        input  start, num_out, out_ready,
        output busy, tap_addr, data_addr, out_idx, mac_clr, mac_en, out_valid, done
    );

    modport slave (
        output start, num_out, out_ready,
        input  busy, tap_addr, data_addr, out_idx, mac_clr, mac_en, out_valid, done
    );
endinterface

// File: rtl/conv1d_tap_sequencer.sv
// rtl/conv1d_tap_sequencer.sv - tap/output-sample loop sequencer feeding the conv1d MAC datapath
module conv1d_tap_sequencer #(
    parameter int TAPS   = 8,
    parameter int ADDR_W = 3,
    parameter int NOUT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    conv1d_tap_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [NOUT_W-1:0] idx_q, idx_d;
    logic [NOUT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tap_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_out != '0) begin
                        cnt_d   = bus.num_out;
                        tap_d   = '0;
                        idx_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = EMIT;
                end else begin
                    tap_d = tap_q + ADDR_W'(1);
                end
            end
            EMIT: begin
                // Result stays presented until the consumer takes it
                if (bus.out_ready) begin
                    if (idx_q == cnt_q - NOUT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + NOUT_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode from registers only
    assign bus.busy      = (state_q != IDLE);
    assign bus.mac_en    = (state_q == ACCUM);
    assign bus.mac_clr   = (state_q == ACCUM) && (tap_q == '0);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.done      = (state_q == DONE);
    assign bus.tap_addr  = tap_q;
    assign bus.out_idx   = idx_q;
    assign bus.data_addr = {1'b0, idx_q} + (NOUT_W + 1)'(tap_q);
endmodule

// File: tb/tb_conv1d_tap_sequencer.sv
// tb/tb_conv1d_tap_sequencer.sv - scoreboard bench for conv1d_tap_sequencer
module tb_conv1d_tap_sequencer;
    localparam int TAPS   = 8;
    localparam int ADDR_W = 3;
    localparam int NOUT_W = 8;
    localparam int PER    = TAPS + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv1d_tap_sequencer_if #(.ADDR_W(ADDR_W), .NOUT_W(NOUT_W)) bus ();

    conv1d_tap_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .NOUT_W(NOUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int kind;   // 0 mac cycle, 1 result handshake, 2 done
        int cyc;
        int tap;
        int daddr;
        int idx;
        int clr;
    } ev_t;

    ev_t exp_q[$];
    int  cyc         = 0;
    int  vectors     = 0;
    int  miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d", name, act, expv, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int tap, input int daddr,
                           input int idx, input int clr);
        ev_t e;
        e.kind = kind; e.cyc = c; e.tap = tap; e.daddr = daddr; e.idx = idx; e.clr = clr;
        exp_q.push_back(e);
    endtask

    // b: cyc value of spec cycle 0; hold: extra wait cycles on first result; limit: drop events at/after b+limit
    task automatic push_run(input int b, input int n, input int hold, input int limit);
        int off = 0;
        int c;
        for (int k = 0; k < n; k++) begin
            for (int t = 0; t < TAPS; t++) begin
                c = b + 1 + k * PER + t + off;
                if (limit == 0 || c < b + limit) push_ev(0, c, t, k + t, k, (t == 0) ? 1 : 0);
            end
            if (k == 0) off = hold;
            c = b + k * PER + PER + off;
            if (limit == 0 || c < b + limit) push_ev(1, c, 0, 0, k, 0);
        end
        c = b + n * PER + 1 + off;
        if (limit == 0 || c < b + limit) push_ev(2, c, 0, 0, 0, 0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input int n, output int b);
        bus.start   = 1'b1;
        bus.num_out = NOUT_W'(n);
        @(posedge clk);
        #1;
        b = cyc - 1;
        bus.start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      int'(bus.busy), 0);
        chk({tag, "_mac_en"},    int'(bus.mac_en), 0);
        chk({tag, "_mac_clr"},   int'(bus.mac_clr), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_done"},      int'(bus.done), 0);
        chk({tag, "_tap_addr"},  int'(bus.tap_addr), 0);
        chk({tag, "_data_addr"}, int'(bus.data_addr), 0);
        chk({tag, "_out_idx"},   int'(bus.out_idx), 0);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d expected none at cyc %0d", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cyc", cyc, e.cyc);
            chk("event_busy", int'(bus.busy), 1);
            if (kind == 0) begin
                chk("tap_addr", int'(bus.tap_addr), e.tap);
                chk("data_addr", int'(bus.data_addr), e.daddr);
                chk("mac_out_idx", int'(bus.out_idx), e.idx);
                chk("mac_clr", int'(bus.mac_clr), e.clr);
            end else if (kind == 1) begin
                chk("emit_out_idx", int'(bus.out_idx), e.idx);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.mac_en) take(0);
        if (bus.out_valid && bus.out_ready) take(1);
        if (bus.done) take(2);
        if (bus.out_valid && !bus.out_ready && exp_q.size() > 0) begin
            chk("hold_out_idx", int'(bus.out_idx), exp_q[0].idx);
            chk("hold_mac_en", int'(bus.mac_en), 0);
        end
    end

    initial begin
        int b;
        int b2;
        bus.start     = 1'b0;
        bus.num_out   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic run
        start_run(3, b);
        push_run(b, 3, 0, 0);
        wait_cyc(b + 29);
        chk("basic_busy_low", int'(bus.busy), 0);
        wait_cyc(b + 31);

        // Address sequence
        start_run(2, b);
        push_run(b, 2, 0, 0);
        wait_cyc(b + 2 * PER + 4);

        // Backpressure on the first result
        bus.out_ready = 1'b0;
        start_run(2, b);
        push_run(b, 2, 5, 0);
        wait_cyc(b + 14);
        bus.out_ready = 1'b1;
        wait_cyc(b + 2 * PER + 5 + 4);

        // Zero-length run
        start_run(0, b);
        push_run(b, 0, 0, 0);
        wait_cyc(b + 4);

        // Start during ACCUM is ignored
        start_run(2, b);
        push_run(b, 2, 0, 0);
        wait_cyc(b + 4);
        bus.start   = 1'b1;
        bus.num_out = NOUT_W'(5);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_cyc(b + 2 * PER + 4);

        // Reset mid-run
        start_run(4, b);
        push_run(b, 4, 0, 12);
        wait_cyc(b + 12);
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("after_reset_queue", exp_q.size(), 0);
        start_run(1, b);
        push_run(b, 1, 0, 0);
        wait_cyc(b + PER + 4);

        // Max count with start held across DONE; num_out change after latch has no effect
        bus.num_out = NOUT_W'(255);
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        b = cyc - 1;
        bus.num_out = NOUT_W'(1);
        push_run(b, 255, 0, 0);
        b2 = b + 255 * PER + 2;
        push_run(b2, 1, 0, 0);
        wait_cyc(b + 255 * PER + 2);
        chk("gap_busy_low", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_cyc(b2 + PER + 4);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conv1d_tap_sequencer.md
Name: conv1d_tap_sequencer

Overview:
- Control stage directly upstream of the conv1d MAC datapath.
- Sequences the tap loop and the output-sample loop for one convolution run.
- Drives coefficient/data read addresses, MAC clear/accumulate strobes and a valid/ready result handshake.
- Reports per-run completion to the system controller.

Parameters:
TAPS, 8, number of filter taps per output sample (>=2)
ADDR_W, 3, tap address width, equal to clog2(TAPS)
NOUT_W, 8, width of output-sample count and index

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  run request, sampled in IDLE only
num_out  input  NOUT_W  number of output samples for the run, latched on accepted start
busy  output  1  high from the cycle after an accepted start until DONE exits
tap_addr  output  ADDR_W  coefficient read address (current tap)
data_addr  output  NOUT_W+1  input-sample read address = out_idx + tap, zero-extended, no wrap
out_idx  output  NOUT_W  index of the output sample being computed/emitted
mac_clr  output  1  MAC loads product instead of accumulating (first tap)
mac_en  output  1  MAC operates this cycle
out_valid  output  1  MAC result for out_idx is ready for consumer
out_ready  input  1  consumer accepts result
done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; tap, out_idx and latched count cleared; every output 0. Applies mid-run: the run is abandoned and no done is issued.
- Outputs decode from registered state/counters only. No combinational path from start or out_ready to outputs.
- IDLE:
  - start=1 with num_out!=0: latch num_out, tap=0, out_idx=0, go ACCUM.
  - start=1 with num_out==0: go DONE directly (done pulse, no MAC activity).
  - start=0: stay.
- ACCUM: mac_en=1 every cycle.
  - mac_clr=1 only while tap==0.
  - tap_addr=tap; data_addr=out_idx+tap.
  - tap increments each cycle. After the tap==TAPS-1 cycle: tap->0, go EMIT.
  - ACCUM lasts exactly TAPS cycles.
- EMIT: out_valid=1, mac_en=0, mac_clr=0.
  - out_valid stays high and out_idx stays stable until out_valid&&out_ready.
  - On handshake with out_idx==latched-1: go DONE.
  - On handshake otherwise: out_idx+1, go ACCUM.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
- busy=1 in ACCUM, EMIT and DONE; 0 in IDLE.
- start is ignored outside IDLE. A start held high across DONE->IDLE is accepted in the first IDLE cycle, so back-to-back runs have a 1-cycle IDLE gap.
- num_out changes after latch have no effect on the current run.
- Timing with out_ready held high, start accepted at edge 0:
  - first mac_en cycle is cycle 1;
  - out_valid is in cycles k*(TAPS+1)+TAPS+1 for k=0..N-1;
  - done is in cycle N*(TAPS+1)+1.
- Arithmetic: counters are unsigned. data_addr max = (2^NOUT_W-1)+(TAPS-1) fits NOUT_W+1 bits for TAPS<=2^NOUT_W. out_idx never wraps because a run ends at latched-1.

Test Plan:
- Reset mid-run: num_out=4, TAPS=8; assert reset at cycle 12 -> all outputs 0 immediately; done never pulses; next start behaves as a fresh run from out_idx=0.
- Basic run: num_out=3, out_ready=1 -> 3 bursts of 8 mac_en cycles. mac_clr only on the first cycle of each burst. out_valid at cycles 9, 18, 27; done at cycle 28; busy low at cycle 29.
- Address check: num_out=2 -> data_addr sequence 0..7 then 1..8; tap_addr 0..7 twice; out_idx 0 then 1.
- Backpressure: num_out=2, out_ready low for 5 cycles after first out_valid -> out_valid and out_idx=0 held stable for 6 cycles, no mac_en during hold. Second burst starts the cycle after the handshake.
- Zero length and ignored start: num_out=0 -> done pulses the cycle after start, no mac_en, no out_valid. start pulsed during ACCUM of a num_out=2 run -> ignored, run unchanged.
- Max count: num_out=255, start held high -> out_idx reaches 254, final data_addr=261, done pulses. Second run begins after one IDLE cycle.
